// File: rtl/spi_sram_port_if.sv
// spi_sram_port_if
// Groups the CPU-side request/response handshake and the four SPI SRAM pins
// of the serial-memory engine into one bundle.
//   addr_in, data_in          : transfer address / write word (start cycle only)
//   start_read, start_write   : single-cycle request pulses
//   data_out, busy            : last completed read word, transaction in progress
//   spi_select, spi_clk_out,
//   spi_mosi, spi_miso        : SPI mode-0 pins (select active-low)
// The slave modport is the engine's view; the master modport is the client's view.
interface spi_sram_port_if #(
    parameter int DATA_WIDTH_BYTES = 2,
    parameter int ADDR_BITS        = 16
);
    logic [ADDR_BITS-1:0]          addr_in;
    logic [8*DATA_WIDTH_BYTES-1:0] data_in;
    logic                          start_read;
    logic                          start_write;
    logic [8*DATA_WIDTH_BYTES-1:0] data_out;
    logic                          busy;
    logic                          spi_select;
    logic                          spi_clk_out;
    logic                          spi_mosi;
    logic                          spi_miso;

    modport slave (
        input  addr_in, data_in, start_read, start_write, spi_miso,
        output data_out, busy, spi_select, spi_clk_out, spi_mosi
    );

    modport master (
        output addr_in, data_in, start_read, start_write, spi_miso,
        input  data_out, busy, spi_select, spi_clk_out, spi_mosi
    );
endinterface

// File: rtl/spi_sram_port.sv
// spi_sram_port
// Serial-memory engine between the CPU core and a 23LC512-class SPI SRAM.
// A start pulse latches command, address and write word into one shift
// register; a full SPI mode-0 transaction (command, address, data) is then
// run at clk/2 and, for reads, the received word is published on data_out.
// Ports:
//   clk  : system clock (only clock)
//   rst  : asynchronous active-high reset
//   bus  : spi_sram_port_if.slave (handshake + SPI pins)
// Data bytes travel little-endian on the wire (word bits [7:0] first),
// MSB-first within each byte, in both directions.
module spi_sram_port #(
    parameter int DATA_WIDTH_BYTES = 2,
    parameter int ADDR_BITS        = 16
) (
    input  logic           clk,
    input  logic           rst,
    spi_sram_port_if.slave bus
);
    localparam int DW    = 8 * DATA_WIDTH_BYTES;
    localparam int N     = 8 + ADDR_BITS + DW;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(N - 1);
    localparam logic [7:0]       CMD_WRITE = 8'h02;
    localparam logic [7:0]       CMD_READ  = 8'h03;

    typedef enum logic [1:0] {IDLE, SELECT, SHIFT, DESELECT} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [N-1:0]     r_tx;
    logic [DW-1:0]    r_rx;
    logic [CNT_W-1:0] r_bitCnt;
    logic             r_phase;
    logic             r_isRead;
    logic [DW-1:0]    r_dataOut;

    logic             w_start;
    logic             w_lastBit;
    logic [DW-1:0]    w_rxNext;

    // Reverses byte order so the word's low byte sits at the wire-first end.
    function automatic logic [DW-1:0] swapBytes(input logic [DW-1:0] word);
        logic [DW-1:0] swapped;
        swapped = '0;
        for (int i = 0; i < DATA_WIDTH_BYTES; i++) begin
            swapped[8*i +: 8] = word[8*(DATA_WIDTH_BYTES-1-i) +: 8];
        end
        return swapped;
    endfunction

    assign w_start   = bus.start_read | bus.start_write;
    assign w_lastBit = r_phase && (r_bitCnt == LAST_BIT);
    assign w_rxNext  = {r_rx[DW-2:0], bus.spi_miso};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; starts outside IDLE fall through unhandled (not queued).
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (w_start) w_nextState = SELECT;
            SELECT:   w_nextState = SHIFT;
            SHIFT:    if (w_lastBit) w_nextState = DESELECT;
            DESELECT: w_nextState = IDLE;
            default:  w_nextState = IDLE;
        endcase
    end

    // Datapath. r_phase=0 is the SPI low phase, 1 the high phase; the edge
    // closing the high phase samples MISO and advances the transmit register.
    // The receive register simply keeps the newest DW bits, which after the
    // final bit are exactly the data field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx      <= '0;
            r_rx      <= '0;
            r_bitCnt  <= '0;
            r_phase   <= 1'b0;
            r_isRead  <= 1'b0;
            r_dataOut <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_tx     <= {(bus.start_write ? CMD_WRITE : CMD_READ),
                                     bus.addr_in, swapBytes(bus.data_in)};
                        r_isRead <= ~bus.start_write;
                        r_bitCnt <= '0;
                        r_phase  <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_tx     <= {r_tx[N-2:0], 1'b0};
                        r_rx     <= w_rxNext;
                        r_bitCnt <= r_bitCnt + CNT_W'(1);
                        if (w_lastBit && r_isRead) begin
                            r_dataOut <= swapBytes(w_rxNext);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode registered state only, so no input reaches an output
    // combinationally.
    always_comb begin
        bus.busy        = (r_state != IDLE);
        bus.spi_select  = !((r_state == SELECT) || (r_state == SHIFT));
        bus.spi_clk_out = (r_state == SHIFT) && r_phase;
        bus.spi_mosi    = ((r_state == SELECT) || (r_state == SHIFT)) ? r_tx[N-1] : 1'b0;
        bus.data_out    = r_dataOut;
    end
endmodule

// File: tb/tb_spi_sram_port.sv
// tb_spi_sram_port
// Directed bench for spi_sram_port with a behavioural 23LC512-style SRAM
// that logs MOSI, counts selects and SCK edges, and serves read data on
// falling SCK edges.
module tb_spi_sram_port;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_sram_port_if bus ();

    spi_sram_port dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  mem [0:65535];
    logic [63:0] mosiLog;
    int          modelBits;
    int          selectCount = 0;
    logic [7:0]  modelCmd;
    logic [15:0] modelAddr;
    time         tDeselect = 0;
    time         tSelect   = 0;
    logic        prevSel   = 1'b1;
    logic        prevSck   = 1'b0;
    int          dataIdx;
    logic [15:0] byteAddr;

    // SRAM model: one process so every model variable has a single writer.
    always @(bus.spi_select or bus.spi_clk_out) begin
        if (prevSel === 1'b1 && bus.spi_select === 1'b0) begin
            modelBits   = 0;
            mosiLog     = '0;
            selectCount = selectCount + 1;
            tSelect     = $time;
            bus.spi_miso = 1'b0;
        end
        if (prevSel === 1'b0 && bus.spi_select === 1'b1) begin
            tDeselect = $time;
        end
        if (prevSck === 1'b0 && bus.spi_clk_out === 1'b1 && bus.spi_select === 1'b0) begin
            mosiLog   = {mosiLog[62:0], bus.spi_mosi};
            modelBits = modelBits + 1;
            if (modelBits == 8)  modelCmd  = mosiLog[7:0];
            if (modelBits == 24) modelAddr = mosiLog[15:0];
        end
        if (prevSck === 1'b1 && bus.spi_clk_out === 1'b0 && modelBits >= 24 && modelBits < 40
            && modelCmd == 8'h03) begin
            dataIdx      = modelBits - 24;
            byteAddr     = modelAddr + 16'(dataIdx / 8);
            bus.spi_miso = mem[byteAddr][7 - (dataIdx % 8)];
        end
        prevSel = bus.spi_select;
        prevSck = bus.spi_clk_out;
    end

    // Presents a request for exactly one clock edge, starting now.
    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [15:0] a, input logic [15:0] d);
        bus.addr_in     = a;
        bus.data_in     = d;
        bus.start_read  = rd;
        bus.start_write = wr;
        @(posedge clk);
        #1;
        bus.start_read  = 1'b0;
        bus.start_write = 1'b0;
    endtask

    // Counts cycles with busy high; leaves us in the first busy-low cycle.
    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 1000) begin
            cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.start_read  = 1'b0;
        bus.start_write = 1'b0;
        bus.addr_in     = '0;
        bus.data_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.spi_select !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_select: got %b expected 1", bus.spi_select); end
        vectors++; if (bus.spi_clk_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sck: got %b expected 0", bus.spi_clk_out); end
        vectors++; if (bus.spi_mosi !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mosi: got %b expected 0", bus.spi_mosi); end
        vectors++; if (bus.data_out !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_data_out: got %h expected 0000", bus.data_out); end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_after_reset: got %b expected 0", bus.busy); end
    endtask

    task automatic test_write();
        int cycles;
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b1, 16'h1234, 16'hBEEF);
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL write_busy_rise: got %b expected 1", bus.busy); end
        waitIdle(cycles);
        vectors++; if (cycles != 82) begin miscompares++; $display("[TB] FAIL write_busy_len: got %0d expected 82", cycles); end
        vectors++; if (mosiLog[39:0] !== 40'h021234EFBE) begin miscompares++; $display("[TB] FAIL write_mosi: got %h expected 021234efbe", mosiLog[39:0]); end
        vectors++; if (modelBits != 40) begin miscompares++; $display("[TB] FAIL write_sck_edges: got %0d expected 40", modelBits); end
        vectors++; if (bus.data_out !== 16'h0000) begin miscompares++; $display("[TB] FAIL write_data_out: got %h expected 0000", bus.data_out); end
    endtask

    task automatic test_read();
        int cycles;
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 16'h00FE, 16'h0000);
        waitIdle(cycles);
        vectors++; if (cycles != 82) begin miscompares++; $display("[TB] FAIL read_busy_len: got %0d expected 82", cycles); end
        vectors++; if (mosiLog[39:16] !== 24'h0300FE) begin miscompares++; $display("[TB] FAIL read_mosi: got %h expected 0300fe", mosiLog[39:16]); end
        vectors++; if (bus.data_out !== 16'h1234) begin miscompares++; $display("[TB] FAIL read_data: got %h expected 1234", bus.data_out); end
    endtask

    task automatic test_ignored_start();
        int cycles;
        int selBefore;
        @(posedge clk); #1;
        selBefore = selectCount;
        applyStimulus(1'b1, 1'b0, 16'h0100, 16'h0000);
        repeat (10) @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 16'h00FE, 16'h0000);
        waitIdle(cycles);
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (selectCount != selBefore + 1) begin miscompares++; $display("[TB] FAIL ignored_selects: got %0d expected %0d", selectCount, selBefore + 1); end
        vectors++; if (modelAddr !== 16'h0100) begin miscompares++; $display("[TB] FAIL ignored_addr: got %h expected 0100", modelAddr); end
        vectors++; if (bus.data_out !== 16'hABCD) begin miscompares++; $display("[TB] FAIL ignored_data: got %h expected abcd", bus.data_out); end
    endtask

    task automatic test_both_starts();
        int cycles;
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b1, 16'h2000, 16'h5A5A);
        waitIdle(cycles);
        vectors++; if (mosiLog[39:32] !== 8'h02) begin miscompares++; $display("[TB] FAIL both_cmd: got %h expected 02", mosiLog[39:32]); end
        vectors++; if (bus.data_out !== 16'hABCD) begin miscompares++; $display("[TB] FAIL both_data_out: got %h expected abcd", bus.data_out); end
    endtask

    task automatic test_back_to_back();
        int cycles;
        int gapCycles;
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 16'h00FE, 16'h0000);
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL fetch_busy: got %b expected 1", bus.busy); end
        waitIdle(cycles);
        vectors++; if (bus.data_out !== 16'h1234) begin miscompares++; $display("[TB] FAIL b2b_first: got %h expected 1234", bus.data_out); end
        applyStimulus(1'b1, 1'b0, 16'h0100, 16'h0000);
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_accept: got %b expected 1", bus.busy); end
        gapCycles = int'((tSelect - tDeselect) / 10);
        vectors++; if (gapCycles != 2) begin miscompares++; $display("[TB] FAIL b2b_gap: got %0d expected 2", gapCycles); end
        waitIdle(cycles);
        vectors++; if (bus.data_out !== 16'hABCD) begin miscompares++; $display("[TB] FAIL b2b_second: got %h expected abcd", bus.data_out); end
    endtask

    task automatic test_reset_mid();
        int cycles;
        int selAfter;
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b1, 16'h3000, 16'h1111);
        selAfter = selectCount;
        repeat (20) @(posedge clk);
        #1;
        vectors++; if (bus.spi_select !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_selected: got %b expected 0", bus.spi_select); end
        #3 rst = 1'b1;
        #1;
        vectors++; if (bus.spi_select !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_rst_select: got %b expected 1", bus.spi_select); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.data_out !== 16'h0000) begin miscompares++; $display("[TB] FAIL mid_rst_data: got %h expected 0000", bus.data_out); end
        vectors++; if (bus.spi_clk_out !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_sck: got %b expected 0", bus.spi_clk_out); end
        #2 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL post_rst_idle: got %b expected 0", bus.busy); end
        vectors++; if (selectCount != selAfter) begin miscompares++; $display("[TB] FAIL post_rst_selects: got %0d expected %0d", selectCount, selAfter); end
        applyStimulus(1'b1, 1'b0, 16'h00FE, 16'h0000);
        waitIdle(cycles);
        vectors++; if (cycles != 82) begin miscompares++; $display("[TB] FAIL recover_busy_len: got %0d expected 82", cycles); end
        vectors++; if (bus.data_out !== 16'h1234) begin miscompares++; $display("[TB] FAIL recover_data: got %h expected 1234", bus.data_out); end
    endtask

    initial begin
        mem[16'h00FE] = 8'h34;
        mem[16'h00FF] = 8'h12;
        mem[16'h0100] = 8'hCD;
        mem[16'h0101] = 8'hAB;
        test_reset();
        test_write();
        test_read();
        test_ignored_start();
        test_both_starts();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
